// File: rtl/max6675_pkg.sv
// Shared types and frame-layout constants for the MAX6675 thermocouple reader.
package max6675_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SCK_LOW  = 3'd2,
    SCK_HIGH = 3'd3,
    CS_HOLD  = 3'd4,
    UPDATE   = 3'd5
  } state_t;

  localparam int FRAME_BITS  = 16;
  localparam int TEMP_MSB    = 14;
  localparam int TEMP_LSB    = 3;
  localparam int OPEN_TC_BIT = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous MAX6675 SO line into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/max6675_spi_reader.sv
// Periodically reads a 16-bit frame from a MAX6675 over SPI and publishes the
// latest complete frame with a valid pulse and a wrapping sample counter.
module max6675_spi_reader
  import max6675_pkg::*;
#(
  parameter int SCK_HALF    = 13,
  parameter int CONV_CYCLES = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        spi_miso,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic [15:0] temp_word,
  output logic [11:0] temp_q2,
  output logic        open_tc,
  output logic        temp_valid,
  output logic [7:0]  sample_seq
);

  localparam int WAIT_W  = $clog2(CONV_CYCLES + 1);
  localparam int PHASE_W = $clog2(SCK_HALF + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS);

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(CONV_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SCK_HALF - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  state_t                  state_reg, state_next;
  logic [WAIT_W-1:0]       wait_cnt_reg, wait_cnt_next;
  logic [PHASE_W-1:0]      phase_cnt_reg, phase_cnt_next;
  logic [BIT_W-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [FRAME_BITS-1:0]   shift_data_reg;
  logic [15:0]             temp_word_reg;
  logic                    temp_valid_reg;
  logic [7:0]              sample_seq_reg;
  logic                    cs_n_reg, cs_n_next;
  logic                    sck_reg, sck_next;
  logic                    miso_sync;
  logic                    phase_done;
  logic                    sample_bit;

  sync_2ff u_miso_sync (
    .clk   (clk),
    .reset (reset),
    .d     (spi_miso),
    .q     (miso_sync)
  );

  assign phase_done = (phase_cnt_reg == PHASE_LAST);
  assign sample_bit = (state_reg == SCK_HIGH) && phase_done;

  // State register plus the registered SPI pins, which follow the next state
  // so they line up with state_reg without any combinational glitching.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      phase_cnt_reg <= '0;
      bit_cnt_reg   <= '0;
      cs_n_reg      <= 1'b1;
      sck_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      phase_cnt_reg <= phase_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      cs_n_reg      <= cs_n_next;
      sck_reg       <= sck_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    phase_cnt_next = '0;
    bit_cnt_next   = bit_cnt_reg;

    if (state_reg inside {CS_SETUP, SCK_LOW, SCK_HIGH, CS_HOLD} && !phase_done) begin
      phase_cnt_next = phase_cnt_reg + PHASE_W'(1);
    end

    case (state_reg)
      IDLE: begin
        // Dropping enable restarts the conversion wait from zero.
        if (!enable) begin
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          wait_cnt_next = '0;
          state_next    = CS_SETUP;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end
      CS_SETUP: if (phase_done) state_next = SCK_LOW;
      SCK_LOW:  if (phase_done) state_next = SCK_HIGH;
      SCK_HIGH: begin
        if (phase_done) begin
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          state_next   = (bit_cnt_reg == BIT_LAST) ? CS_HOLD : SCK_LOW;
        end
      end
      CS_HOLD:  if (phase_done) state_next = UPDATE;
      UPDATE: begin
        state_next    = IDLE;
        wait_cnt_next = '0;
        bit_cnt_next  = '0;
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = '0;
        bit_cnt_next  = '0;
      end
    endcase
  end

  always_comb begin
    cs_n_next = !(state_next inside {CS_SETUP, SCK_LOW, SCK_HIGH, CS_HOLD});
    sck_next  = (state_next == SCK_HIGH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_data_reg <= '0;
      temp_word_reg  <= '0;
      temp_valid_reg <= 1'b0;
      sample_seq_reg <= '0;
    end else begin
      temp_valid_reg <= (state_reg == UPDATE);
      if (sample_bit) begin
        shift_data_reg <= {shift_data_reg[FRAME_BITS-2:0], miso_sync};
      end
      if (state_reg == UPDATE) begin
        temp_word_reg  <= shift_data_reg;
        sample_seq_reg <= sample_seq_reg + 8'd1;
      end
    end
  end

  assign spi_sck    = sck_reg;
  assign spi_cs_n   = cs_n_reg;
  assign temp_word  = temp_word_reg;
  assign temp_q2    = temp_word_reg[TEMP_MSB:TEMP_LSB];
  assign open_tc    = temp_word_reg[OPEN_TC_BIT];
  assign temp_valid = temp_valid_reg;
  assign sample_seq = sample_seq_reg;

endmodule

// File: tb/tb_max6675_spi_reader.sv
// Scoreboard bench for max6675_spi_reader driven by a behavioural MAX6675 model.
module tb_max6675_spi_reader;

  localparam int SCK_HALF    = 4;
  localparam int CONV_CYCLES = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        spi_miso = 1'b0;
  logic        spi_sck;
  logic        spi_cs_n;
  logic [15:0] temp_word;
  logic [11:0] temp_q2;
  logic        open_tc;
  logic        temp_valid;
  logic [7:0]  sample_seq;

  always #5 clk = ~clk;

  max6675_spi_reader #(
    .SCK_HALF    (SCK_HALF),
    .CONV_CYCLES (CONV_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .spi_miso   (spi_miso),
    .spi_sck    (spi_sck),
    .spi_cs_n   (spi_cs_n),
    .temp_word  (temp_word),
    .temp_q2    (temp_q2),
    .open_tc    (open_tc),
    .temp_valid (temp_valid),
    .sample_seq (sample_seq)
  );

  typedef struct {
    logic [15:0] word;
    logic [11:0] q2;
    logic        open;
    logic [7:0]  seq;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          exp_seq = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endfunction

  // MAX6675 model: D15 appears when CS falls, next bit on each SCK fall.
  logic [15:0] model_word = 16'h0000;
  int          model_idx = 0;

  always @(negedge spi_cs_n) begin
    model_word = (model_q.size() != 0) ? model_q.pop_front() : 16'h0000;
    model_idx  = 15;
    spi_miso   = model_word[15];
  end

  always @(negedge spi_sck) begin
    if (!spi_cs_n && model_idx > 0) begin
      model_idx = model_idx - 1;
      spi_miso  = model_word[model_idx];
    end
  end

  // Monitor: every temp_valid pulse is matched against the oldest expectation.
  initial begin
    exp_t e;
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (temp_valid) begin
        check("valid_width", int'(prev_v), 0);
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("temp_word", int'(temp_word), int'(e.word));
          check("temp_q2", int'(temp_q2), int'(e.q2));
          check("open_tc", int'(open_tc), int'(e.open));
          check("sample_seq", int'(sample_seq), int'(e.seq));
          $display("frame word=0x%04h q2=%0d open=%0d seq=%0d", temp_word, temp_q2, open_tc, sample_seq);
        end
      end
      prev_v = temp_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] w, input int q2, input logic open);
    exp_t e;
    exp_seq = (exp_seq + 1) % 256;
    e.word  = w;
    e.q2    = 12'(q2);
    e.open  = open;
    e.seq   = 8'(exp_seq);
    sb_q.push_back(e);
    model_q.push_back(w);
  endtask

  task automatic wait_cs_fall(input string name, output int n);
    n = 0;
    while (spi_cs_n && n < 1000) begin
      tick();
      n++;
    end
    check(name, int'(spi_cs_n), 0);
  endtask

  task automatic wait_rises(input int target);
    int   r;
    int   t;
    logic p;
    r = 0;
    t = 0;
    p = spi_sck;
    while (r < target && t < 500) begin
      tick();
      if (spi_sck && !p) r++;
      p = spi_sck;
      t++;
    end
    check("rise_wait", r, target);
  endtask

  task automatic wait_sb_empty(input int limit);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < limit) begin
      tick();
      t++;
    end
    check("sb_drain", sb_q.size(), 0);
  endtask

  // Entered on the first sampled cycle with cs_n low; returns at cs_n rise.
  task automatic measure_frame(output int low_len, output int rises,
                               output int first_rise, output int bad_w);
    int   hi;
    int   lo;
    logic prev_sck;
    low_len = 0; rises = 0; first_rise = -1; bad_w = 0;
    hi = 0; lo = 0; prev_sck = 1'b0;
    while (!spi_cs_n && low_len < 400) begin
      low_len++;
      if (spi_sck && !prev_sck) begin
        rises++;
        if (first_rise < 0) first_rise = low_len - 1;
        else if (lo != SCK_HALF) bad_w++;
        lo = 0;
      end
      if (!spi_sck && prev_sck) begin
        if (hi != SCK_HALF) bad_w++;
        hi = 0;
      end
      if (spi_sck) hi++;
      else lo++;
      prev_sck = spi_sck;
      tick();
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fall1;
    int low_len;
    int rises;
    int first_rise;
    int bad_w;
    int lows;
    logic [15:0] w;

    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", int'(spi_cs_n), 1);
    check("rst_sck", int'(spi_sck), 0);
    check("rst_temp_word", int'(temp_word), 0);
    check("rst_temp_valid", int'(temp_valid), 0);
    check("rst_sample_seq", int'(sample_seq), 0);

    // Two frames back to back: 100.00 C, then open thermocouple.
    @(negedge clk);
    reset   = 1'b0;
    exp_seq = 0;
    push_frame(16'h0C80, 400, 1'b0);
    push_frame(16'h0004, 0, 1'b1);
    wait_cs_fall("first_fall", n);
    check("first_frame_delay", n, 100);
    fall1 = cyc;
    measure_frame(low_len, rises, first_rise, bad_w);
    check("cs_low_len", low_len, 136);
    check("sck_rises", rises, 16);
    check("first_rise", first_rise, 8);
    check("sck_width_errs", bad_w, 0);
    wait_cs_fall("second_fall", n);
    check("frame_period", cyc - fall1, 237);
    wait_sb_empty(600);

    // Reset while bit 7 is being clocked: partial frame is discarded.
    model_q.push_back(16'hFFFF);
    wait_cs_fall("abort_fall", n);
    wait_rises(7);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_cs_n", int'(spi_cs_n), 1);
    check("midrst_sck", int'(spi_sck), 0);
    check("midrst_temp_word", int'(temp_word), 0);
    check("midrst_sample_seq", int'(sample_seq), 0);
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    exp_seq = 0;
    push_frame(16'h7FF8, 4095, 1'b0);
    wait_cs_fall("rst_restart_fall", n);
    check("rst_restart_delay", n, 100);
    wait_sb_empty(400);

    // Enable dropped during bit 3: frame still completes, then cs_n idles high.
    push_frame(16'h0AB8, 343, 1'b0);
    wait_cs_fall("en_frame_fall", n);
    wait_rises(3);
    enable = 1'b0;
    wait_sb_empty(400);
    lows = 0;
    repeat (300) begin
      tick();
      if (!spi_cs_n) lows++;
    end
    check("cs_held_while_disabled", lows, 0);
    push_frame(16'h1F40, 1000, 1'b0);
    enable = 1'b1;
    wait_cs_fall("en_restart_fall", n);
    check("en_restart_delay", n, 100);
    wait_sb_empty(400);

    // 256 frames from reset: the 256th pulse carries sample_seq = 0.
    reset = 1'b1;
    tick();
    @(negedge clk);
    reset   = 1'b0;
    exp_seq = 0;
    for (int i = 1; i <= 256; i++) begin
      w = 16'(i << 3) | ((i % 2 == 1) ? 16'h0004 : 16'h0000);
      push_frame(w, i, 1'(i % 2));
    end
    wait_sb_empty(256 * 237 + 1000);
    check("seq_wrapped", int'(sample_seq), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
